// File: rtl/mips_int_pkg.sv
// mips_int_pkg: shared types and constants for the mips interrupt sequencer.
package mips_int_pkg;

    // Sequencer states: idle, waiting for a safe commit point, running the handler.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        HANDLER = 2'd2
    } int_state_e;

    // Default handler vector and synchroniser depth.
    localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_000C;
    localparam int          SYNC_STAGES_DEF  = 2;

    // Width of the handler-entry counter.
    localparam int          INT_CNT_W        = 16;

    // An EXE instruction is a safe commit point when it is real, not in a
    // branch delay slot (EPC could not express the branch), and not frozen.
    function automatic logic is_safe(input logic valid,
                                     input logic in_delay_slot,
                                     input logic stall);
        return valid & ~in_delay_slot & ~stall;
    endfunction

endpackage

// File: rtl/mips_int_sync.sv
// mips_int_sync: multi-flop synchroniser for the asynchronous interrupter line
// followed by a rising-edge detector producing a one-cycle pulse.
module mips_int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw line through the synchroniser and remember the last synced value.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every flop gets an explicit reset value so no X escapes the synchroniser.
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous stage's old value.
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A 0->1 transition of the synced level is one new request.
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/mips_int_ctrl.sv
// mips_int_ctrl: interrupt sequencer for the pipelined mips core.
// Latches a synchronised request edge as pending, waits for a safe EXE
// instruction, flushes and redirects to the handler, saves EPC and masks entry
// until ERET redirects back to EPC.
// Optional feature: define MIPS_INT_CNT_EN to add the int_count entry counter.
module mips_int_ctrl
    import mips_int_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
    parameter int          SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter logic        IE_RESET     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interrupter,
    input  logic        exe_valid,
    input  logic [31:0] exe_pc,
    input  logic        exe_in_delay_slot,
    input  logic        exe_eret,
    input  logic        pipe_stall,
    input  logic        ie_we,
    input  logic        ie_wdata,
    output logic        ir_redirect,
    output logic [31:0] ir_target,
    output logic [31:0] epc,
    output logic        ie,
    output logic        int_pending,
    output logic        in_handler
`ifdef MIPS_INT_CNT_EN
    ,
    output logic [INT_CNT_W-1:0] int_count
`endif
);

    int_state_e  state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] epc_q, epc_d;
    logic        ie_q, ie_d;

    logic        sync_rise;
    logic        safe;
    logic        eret_take;

    mips_int_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (interrupter),
        .rise_o  (sync_rise)
    );

    assign safe      = is_safe(exe_valid, exe_in_delay_slot, pipe_stall);
    assign eret_take = exe_eret & exe_valid & ~pipe_stall;

    // Next-state logic: sequencing, the one-cycle redirect and EPC/IE/pending updates.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d     = state_q;
        pending_d   = pending_q | sync_rise;
        epc_d       = epc_q;
        ie_d        = ie_we ? ie_wdata : ie_q;
        ir_redirect = 1'b0;

        case (state_q)
            IDLE: begin
                // ERET with nothing to return from is ignored here.
                if (pending_q && ie_q) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (!ie_q) begin
                    // Software masked us while waiting; keep the request pending.
                    state_d = IDLE;
                end else if (safe) begin
                    // Squash EXE and re-execute it after ERET. A request edge in
                    // this same cycle stays pending as a new request.
                    ir_redirect = 1'b1;
                    epc_d       = exe_pc;
                    pending_d   = sync_rise;
                    ie_d        = 1'b0;
                    state_d     = HANDLER;
                end
            end

            HANDLER: begin
                if (eret_take) begin
                    ir_redirect = 1'b1;
                    ie_d        = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and architectural registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            epc_q     <= '0;
            ie_q      <= IE_RESET;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            epc_q     <= epc_d;
            ie_q      <= ie_d;
        end
    end

    // The redirect target is the handler vector except when returning from it.
    assign ir_target   = (state_q == HANDLER) ? epc_q : HANDLER_ADDR;
    assign epc         = epc_q;
    assign ie          = ie_q;
    assign int_pending = pending_q;
    assign in_handler  = (state_q == HANDLER);

`ifdef MIPS_INT_CNT_EN
    logic                 enter;
    logic [INT_CNT_W-1:0] int_count_q;

    assign enter = ir_redirect & (state_q == WAIT);

    // Count handler entries; wraps naturally at the counter width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_count_q <= '0;
        end else if (enter) begin
            int_count_q <= int_count_q + 1'b1;
        end
    end

    assign int_count = int_count_q;
`endif

endmodule

// File: tb/tb_mips_int_ctrl.sv
// tb_mips_int_ctrl: self-checking bench for mips_int_ctrl. A behavioural model
// tracks request edges, the enable bit, EPC and whether the core is waiting or
// inside the handler; directed scenarios also check fixed expected values.
// Define MIPS_INT_CNT_EN to also exercise int_count.
module tb_mips_int_ctrl;

    localparam int          S     = 2;
    localparam logic [31:0] HADDR = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        interrupter;
    logic        exe_valid;
    logic [31:0] exe_pc;
    logic        exe_in_delay_slot;
    logic        exe_eret;
    logic        pipe_stall;
    logic        ie_we;
    logic        ie_wdata;
    logic        ir_redirect;
    logic [31:0] ir_target;
    logic [31:0] epc;
    logic        ie;
    logic        int_pending;
    logic        in_handler;
`ifdef MIPS_INT_CNT_EN
    logic [15:0] int_count;
`endif

    mips_int_ctrl #(
        .HANDLER_ADDR (HADDR),
        .SYNC_STAGES  (S),
        .IE_RESET     (1'b1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .interrupter       (interrupter),
        .exe_valid         (exe_valid),
        .exe_pc            (exe_pc),
        .exe_in_delay_slot (exe_in_delay_slot),
        .exe_eret          (exe_eret),
        .pipe_stall        (pipe_stall),
        .ie_we             (ie_we),
        .ie_wdata          (ie_wdata),
        .ir_redirect       (ir_redirect),
        .ir_target         (ir_target),
        .epc               (epc),
        .ie                (ie),
        .int_pending       (int_pending),
        .in_handler        (in_handler)
`ifdef MIPS_INT_CNT_EN
        ,
        .int_count         (int_count)
`endif
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: raw request samples, and the architectural picture.
    bit          hist[$];
    bit          m_pending, m_ie, m_wait, m_in_h;
    logic [31:0] m_epc;
    logic [15:0] m_cnt;

    // Per-cycle expected/observed redirect, plus redirect log.
    logic        exp_redir, obs_redir;
    logic [31:0] exp_target, obs_target;
    int          redir_seen;
    logic [31:0] last_target;

    task automatic model_reset();
        hist.delete();
        repeat (S + 1) hist.push_back(1'b0);
        m_pending = 1'b0;
        m_ie      = 1'b1;
        m_wait    = 1'b0;
        m_in_h    = 1'b0;
        m_epc     = '0;
        m_cnt     = '0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    // hist[0..S] hold the request line as seen at the last S+1 edges; the
    // synchronised line shows a new rising edge when hist[1] is high after hist[0] low.
    task automatic model_edge();
        bit rise, entry, ret, p_old, ie_old;
        rise   = hist[1] & ~hist[0];
        entry  = m_wait & m_ie & exe_valid & ~exe_in_delay_slot & ~pipe_stall;
        ret    = m_in_h & exe_eret & exe_valid & ~pipe_stall;
        p_old  = m_pending;
        ie_old = m_ie;
        if (entry) begin
            m_epc     = exe_pc;
            m_ie      = 1'b0;
            m_pending = rise;
            m_wait    = 1'b0;
            m_in_h    = 1'b1;
            m_cnt     = m_cnt + 16'd1;
        end else if (ret) begin
            m_ie      = 1'b1;
            m_in_h    = 1'b0;
            m_pending = m_pending | rise;
        end else begin
            if (ie_we) m_ie = ie_wdata;
            m_pending = m_pending | rise;
            if (m_wait && !ie_old) m_wait = 1'b0;
            else if (!m_wait && !m_in_h && p_old && ie_old) m_wait = 1'b1;
        end
        hist.push_back(interrupter);
        void'(hist.pop_front());
    endtask

    // One clock cycle: caller has driven inputs at posedge+1; sample the
    // combinational redirect at posedge+2, then step through the next edge.
    task automatic cycle();
        #1;
        exp_redir  = (m_wait & m_ie & exe_valid & ~exe_in_delay_slot & ~pipe_stall)
                   | (m_in_h & exe_eret & exe_valid & ~pipe_stall);
        exp_target = m_in_h ? m_epc : HADDR;
        obs_redir  = ir_redirect;
        obs_target = ir_target;
        if (obs_redir === 1'b1) begin
            redir_seen++;
            last_target = obs_target;
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // A redirect must never coincide with a stalled pipeline.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (ir_redirect === 1'b1 && pipe_stall === 1'b1) begin
                failures++;
                $display("FAIL stall_redirect t=%0t got redirect=1 while stalled, want 0", $time);
            end
        end
    end

    task automatic idle_inputs();
        interrupter       = 1'b0;
        exe_valid         = 1'b0;
        exe_pc            = '0;
        exe_in_delay_slot = 1'b0;
        exe_eret          = 1'b0;
        pipe_stall        = 1'b0;
        ie_we             = 1'b0;
        ie_wdata          = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #100;
        model_reset();
        checks++;
        if ({ir_redirect, ie, int_pending, in_handler} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_flags got redir/ie/pend/inh=%b%b%b%b want 0100",
                     ir_redirect, ie, int_pending, in_handler);
        end
        checks++;
        if (epc !== 32'h0 || ir_target !== HADDR) begin
            failures++;
            $display("FAIL reset_regs got epc=%h target=%h want epc=0 target=%h", epc, ir_target, HADDR);
        end
`ifdef MIPS_INT_CNT_EN
        checks++;
        if (int_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_count got %0d want 0", int_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Pulse the request and wait (bounded) until the handler is entered at pc.
    task automatic enter_handler(input logic [31:0] pc, input string tag);
        exe_valid = 1'b1; exe_in_delay_slot = 1'b0; pipe_stall = 1'b0; exe_eret = 1'b0;
        exe_pc = pc; interrupter = 1'b1; redir_seen = 0;
        for (int k = 0; k < 15 && !m_in_h; k++) begin
            if (k == 2) interrupter = 1'b0;
            cycle();
            checks++;
            if (obs_redir !== exp_redir || obs_target !== exp_target) begin
                failures++;
                $display("FAIL %s_enter_redir got %b/%h want %b/%h", tag, obs_redir, obs_target, exp_redir, exp_target);
            end
        end
        interrupter = 1'b0;
        checks++;
        if (in_handler !== 1'b1 || redir_seen != 1 || last_target !== HADDR || epc !== pc) begin
            failures++;
            $display("FAIL %s_entry got inh=%b redirs=%0d target=%h epc=%h want 1/1/%h/%h",
                     tag, in_handler, redir_seen, last_target, epc, HADDR, pc);
        end
    endtask

    // Issue one ERET from the handler and check the return redirect.
    task automatic leave_handler(input logic [31:0] ret_pc, input string tag);
        exe_valid = 1'b1; pipe_stall = 1'b0; exe_eret = 1'b1;
        cycle();
        exe_eret = 1'b0;
        checks++;
        if (obs_redir !== 1'b1 || obs_target !== ret_pc || ie !== 1'b1 || in_handler !== 1'b0) begin
            failures++;
            $display("FAIL %s_eret got redir=%b target=%h ie=%b inh=%b want 1/%h/1/0",
                     tag, obs_redir, obs_target, ie, in_handler, ret_pc);
        end
    endtask

    task automatic test_basic_entry();
        enter_handler(32'h0000_0020, "basic");
        checks++;
        if (ie !== 1'b0 || int_pending !== 1'b0) begin
            failures++;
            $display("FAIL basic_mask got ie=%b pend=%b want 0/0", ie, int_pending);
        end
        leave_handler(32'h0000_0020, "basic");
    endtask

    task automatic test_delay_stall();
        exe_valid = 1'b1; exe_in_delay_slot = 1'b1; exe_pc = 32'h40;
        interrupter = 1'b1;
        for (int k = 0; k < 20 && !m_wait; k++) begin
            if (k == 2) interrupter = 1'b0;
            cycle();
        end
        interrupter = 1'b0;
        checks++;
        if (!m_wait) begin
            failures++;
            $display("FAIL ds_timeout got no wait state within 20 cycles, want wait");
        end
        redir_seen = 0;
        for (int k = 0; k < 5; k++) begin
            exe_in_delay_slot = (k < 3);
            pipe_stall        = (k >= 3);
            exe_pc            = 32'h44 + 32'(4 * k);
            cycle();
            checks++;
            if (obs_redir !== exp_redir || obs_target !== exp_target) begin
                failures++;
                $display("FAIL ds_blocked got %b/%h want %b/%h", obs_redir, obs_target, exp_redir, exp_target);
            end
        end
        checks++;
        if (redir_seen != 0) begin
            failures++;
            $display("FAIL ds_no_redirect got %0d redirects want 0", redir_seen);
        end
        exe_in_delay_slot = 1'b0; pipe_stall = 1'b0; exe_pc = 32'h100;
        cycle();
        checks++;
        if (obs_redir !== 1'b1 || obs_target !== HADDR || epc !== 32'h100) begin
            failures++;
            $display("FAIL ds_entry got redir=%b target=%h epc=%h want 1/%h/00000100",
                     obs_redir, obs_target, epc, HADDR);
        end
        leave_handler(32'h100, "ds");
    endtask

    task automatic test_edge_in_handler();
        enter_handler(32'h80, "hedge");
        interrupter = 1'b1; redir_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) interrupter = 1'b0;
            cycle();
            checks++;
            if ({ie, int_pending, in_handler, epc} !== {m_ie, m_pending, m_in_h, m_epc}) begin
                failures++;
                $display("FAIL hedge_state got ie=%b pend=%b inh=%b epc=%h want %b/%b/%b/%h",
                         ie, int_pending, in_handler, epc, m_ie, m_pending, m_in_h, m_epc);
            end
        end
        checks++;
        if (redir_seen != 0 || int_pending !== 1'b1 || in_handler !== 1'b1) begin
            failures++;
            $display("FAIL hedge_pending got redirs=%0d pend=%b inh=%b want 0/1/1", redir_seen, int_pending, in_handler);
        end
        leave_handler(32'h80, "hedge");
        exe_pc = 32'h84; redir_seen = 0;
        for (int k = 0; k < 3; k++) cycle();
        checks++;
        if (redir_seen != 1 || last_target !== HADDR || epc !== 32'h84) begin
            failures++;
            $display("FAIL hedge_reentry got redirs=%0d target=%h epc=%h want 1/%h/00000084",
                     redir_seen, last_target, epc, HADDR);
        end
        leave_handler(32'h84, "hedge2");
    endtask

    task automatic test_mask();
        ie_we = 1'b1; ie_wdata = 1'b0;
        cycle();
        ie_we = 1'b0;
        exe_valid = 1'b1; exe_pc = 32'h200; interrupter = 1'b1; redir_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) interrupter = 1'b0;
            cycle();
        end
        checks++;
        if (int_pending !== 1'b1 || in_handler !== 1'b0 || ie !== 1'b0 || redir_seen != 0) begin
            failures++;
            $display("FAIL mask_hold got pend=%b inh=%b ie=%b redirs=%0d want 1/0/0/0",
                     int_pending, in_handler, ie, redir_seen);
        end
        ie_we = 1'b1; ie_wdata = 1'b1;
        cycle();
        ie_we = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        checks++;
        if (redir_seen != 1 || last_target !== HADDR || in_handler !== 1'b1) begin
            failures++;
            $display("FAIL mask_release got redirs=%0d target=%h inh=%b want 1/%h/1",
                     redir_seen, last_target, in_handler, HADDR);
        end
        leave_handler(32'h200, "mask");
        exe_eret = 1'b1; redir_seen = 0;
        for (int k = 0; k < 3; k++) cycle();
        exe_eret = 1'b0;
        checks++;
        if (redir_seen != 0 || in_handler !== 1'b0 || ie !== 1'b1) begin
            failures++;
            $display("FAIL stray_eret got redirs=%0d inh=%b ie=%b want 0/0/1", redir_seen, in_handler, ie);
        end
    endtask

    task automatic test_reset_in_handler();
        enter_handler(32'h300, "rsth");
        rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if ({ir_redirect, ie, int_pending, in_handler} !== 4'b0100 || epc !== 32'h0) begin
            failures++;
            $display("FAIL rst_handler got redir/ie/pend/inh=%b%b%b%b epc=%h want 0100 epc=0",
                     ir_redirect, ie, int_pending, in_handler, epc);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
`ifdef MIPS_INT_CNT_EN
        for (int n = 0; n < 3; n++) begin
            enter_handler(32'h400 + 32'(8 * n), "cnt");
            leave_handler(32'h400 + 32'(8 * n), "cnt");
        end
        checks++;
        if (int_count !== 16'd3) begin
            failures++;
            $display("FAIL count_three got %0d want 3", int_count);
        end
        rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if (int_count !== 16'd0) begin
            failures++;
            $display("FAIL count_reset got %0d want 0", int_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) interrupter = ~interrupter;
            exe_valid         = ($urandom_range(0, 3) != 0);
            exe_in_delay_slot = ($urandom_range(0, 3) == 0);
            pipe_stall        = ($urandom_range(0, 4) == 0);
            exe_eret          = m_in_h ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0);
            ie_we             = ($urandom_range(0, 19) == 0);
            ie_wdata          = ($urandom_range(0, 2) != 0);
            exe_pc            = $urandom & 32'hFFFF_FFFC;
            cycle();
            checks++;
            if (obs_redir !== exp_redir || obs_target !== exp_target) begin
                failures++;
                $display("FAIL rand_redir k=%0d got %b/%h want %b/%h", k, obs_redir, obs_target, exp_redir, exp_target);
            end
            checks++;
            if ({ie, int_pending, in_handler, epc} !== {m_ie, m_pending, m_in_h, m_epc}) begin
                failures++;
                $display("FAIL rand_state k=%0d got ie=%b pend=%b inh=%b epc=%h want %b/%b/%b/%h",
                         k, ie, int_pending, in_handler, epc, m_ie, m_pending, m_in_h, m_epc);
            end
`ifdef MIPS_INT_CNT_EN
            checks++;
            if (int_count !== m_cnt) begin
                failures++;
                $display("FAIL rand_count k=%0d got %0d want %0d", k, int_count, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_delay_stall();
        test_edge_in_handler();
        test_mask();
        test_reset_in_handler();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
